// File: rtl/polylut_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : polylut_stage_reg_if
// Purpose  : Valid/ready stream carrying one packed activation vector.
// Revision : 1.0  initial release
// ============================================================================
interface polylut_stage_reg_if #(
    parameter int DATA_W = 112
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/polylut_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : polylut_stage_reg
// Purpose  : Inter-layer pipeline stage; single-entry (MODE 0) or skid (MODE 1).
// Revision : 1.0  initial release
// ============================================================================
module polylut_stage_reg #(
    parameter int DATA_W = 112,
    parameter int MODE   = 1,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    polylut_stage_reg_if.slave  in_if,
    polylut_stage_reg_if.master out_if,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);
    localparam logic [1:0]       ST_EMPTY = 2'd0;
    localparam logic [1:0]       ST_ONE   = 2'd1;
    localparam logic [1:0]       ST_TWO   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_ready;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_if.valid & in_ready;
    assign out_fire  = out_valid & out_if.ready;

    generate
        if (MODE == 1) begin : g_skid_ready
            // Registered ready: asserted exactly when the next state is not full.
            logic rdy_q;
            always_ff @(posedge clk) begin
                if (rst) rdy_q <= 1'b1;
                else     rdy_q <= (state_d != ST_TWO);
            end
            assign in_ready = rdy_q & ~rst;
        end else begin : g_comb_ready
            assign in_ready = ~rst & (~out_valid | out_if.ready);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;
        if (out_valid && !out_if.ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_ONE;
        end
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_if.data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_if.data;
                    end else if (in_fire && (MODE == 1)) begin
                        state_d = ST_TWO;
                        skid_d  = in_if.data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_if.ready  = in_ready;
        out_if.valid = out_valid;
        out_if.data  = main_q;
        stall_cnt    = stall_q;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_polylut_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_polylut_stage_reg
// Purpose  : Scoreboard bench driving one MODE 0 and one MODE 1 stage.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_polylut_stage_reg;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          out_ready [2];
    logic [DW-1:0] in_data   [2];

    logic          rdy_w [2];
    logic          vld_w [2];
    logic [DW-1:0] dat_w [2];
    logic [1:0]    occ_w [2];
    logic [CW-1:0] stl_w [2];

    int            n_tests = 0;
    int            n_fail  = 0;
    bit            started = 1'b0;
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    int            cnt [2];
    bit            dz  [2];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            polylut_stage_reg_if #(.DATA_W(DW)) u_in  ();
            polylut_stage_reg_if #(.DATA_W(DW)) u_out ();
            assign u_in.data    = in_data[g];
            assign u_in.valid   = in_valid[g];
            assign u_out.ready  = out_ready[g];
            assign rdy_w[g]     = u_in.ready;
            assign vld_w[g]     = u_out.valid;
            assign dat_w[g]     = u_out.data;
            polylut_stage_reg #(.DATA_W(DW), .MODE(g), .CNT_W(CW)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush[g]),
                .in_if     (u_in),
                .out_if    (u_out),
                .occupancy (occ_w[g]),
                .stall_cnt (stl_w[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s mode%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Reference: a FIFO of accepted words, capacity 2 (MODE 1) or 1 (MODE 0).
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic [DW-1:0] q[$];
                bit erdy, ovl, ofire, ifire;
                if (i == 0) q = sb0; else q = sb1;
                ovl  = (q.size() != 0);
                erdy = !rst && ((i == 1) ? (q.size() < 2) : (!ovl || out_ready[i]));
                chk("in_ready",  i, 32'(rdy_w[i]), 32'(erdy));
                chk("out_valid", i, 32'(vld_w[i]), 32'(ovl));
                chk("occupancy", i, 32'(occ_w[i]), 32'(q.size()));
                chk("stall_cnt", i, 32'(stl_w[i]), 32'(cnt[i]));
                if (ovl)        chk("out_data", i, 32'(dat_w[i]), 32'(q[0]));
                else if (dz[i]) chk("out_data_zero", i, 32'(dat_w[i]), 32'd0);
                if (rst) begin
                    q.delete();
                    cnt[i] = 0;
                    dz[i]  = 1'b1;
                end else begin
                    ofire = ovl && out_ready[i];
                    ifire = in_valid[i] && erdy;
                    if (ovl && !out_ready[i] && cnt[i] < CMAX) cnt[i]++;
                    if (ofire) void'(q.pop_front());
                    if (flush[i]) begin
                        q.delete();
                        dz[i] = 1'b1;
                    end else if (ifire) begin
                        q.push_back(in_data[i]);
                        dz[i] = 1'b0;
                    end
                end
                if (i == 0) sb0 = q; else sb1 = q;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            flush[i]     = 1'b0;
            in_valid[i]  = 1'b1;
            out_ready[i] = 1'b0;
            in_data[i]   = 16'hA5;
            cnt[i]       = 0;
            dz[i]        = 1'b1;
        end
        @(posedge clk);
        started = 1'b1;
        #1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        cyc(2);

        // Streaming 0x01..0x10 with continuous out_ready
        for (int k = 1; k <= 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = 1'b1;
                in_data[i]   = DW'(k);
                out_ready[i] = 1'b1;
            end
            cyc();
        end
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        cyc(3);

        // Skid on the MODE 1 stage
        in_valid[1] = 1'b1; in_data[1] = 16'h1; out_ready[1] = 1'b1; cyc();
        out_ready[1] = 1'b0; in_data[1] = 16'h2; cyc();
        in_data[1] = 16'h3; cyc(4);
        out_ready[1] = 1'b1; cyc(2);
        in_valid[1] = 1'b0; cyc(3);

        // Combinational ready on the MODE 0 stage
        out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 16'h55; cyc();
        in_data[0] = 16'h7; cyc(3);
        out_ready[0] = 1'b1; cyc();
        in_valid[0] = 1'b0; cyc(2);

        // Flush while full, then flush while accepting
        out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 16'hB; cyc();
        in_data[1] = 16'hC; cyc();
        in_data[1] = 16'hD; flush[1] = 1'b1; cyc();
        flush[1] = 1'b0; in_valid[1] = 1'b0; cyc(2);
        in_valid[1] = 1'b1; in_data[1] = 16'hE; cyc();
        in_data[1] = 16'hF; flush[1] = 1'b1; cyc();
        flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b1; cyc(3);

        // Saturation of the stall counter, cleared only by rst
        for (int i = 0; i < 2; i++) begin
            out_ready[i] = 1'b0; in_valid[i] = 1'b1; in_data[i] = 16'h99;
        end
        cyc();
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        cyc(20);
        flush[0] = 1'b1; flush[1] = 1'b1; cyc();
        flush[0] = 1'b0; flush[1] = 1'b0; cyc(2);
        rst = 1'b1; cyc();
        rst = 1'b0; cyc(2);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                in_data[i]   = DW'($urandom);
                out_ready[i] = ($urandom_range(0, 2) != 0);
                flush[i]     = ($urandom_range(0, 40) == 0);
            end
            rst = ($urandom_range(0, 250) == 0);
            cyc();
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; flush[i] = 1'b0; out_ready[i] = 1'b1;
        end
        cyc(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/polylut_stage_reg.md
# polylut_stage_reg

Parametrised inter-layer pipeline stage for the PolyLUT-Add datapath. It is the successor to the plain enable-free stage register. It carries a layer's packed activation vector together with a valid/ready handshake, so that layers and adders can stall, flush and run with backpressure. One instance sits between each adder output and the next layer input, and one sits at the network input. MODE selects a minimal single-entry register or a full-throughput two-entry skid buffer with a registered ready.

## Interface
- DATA_W, 112, width of the packed activation vector (e.g. 112, 640, 320).
- MODE, 1, 0 = single-entry register with combinational ready; 1 = two-entry skid buffer with registered ready.
- CNT_W, 32, width of the stall-cycle counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held words.
- in_data  input  DATA_W  activation vector from the upstream adder.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  stage accepts in_data this cycle.
- out_data  output  DATA_W  activation vector to the downstream layer.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- occupancy  output  2  number of words held (0, 1 or 2).
- stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) plus, in MODE 1 only, a skid register.
- Output: out_valid = (state != EMPTY); out_data = main.
- MODE 1 states and transitions:
  - EMPTY: in_ready=1. in_fire -> ONE, main<=in_data.
  - ONE: in_ready=1.
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire & !out_fire -> TWO, skid<=in_data.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - TWO: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- MODE 1 in_ready comes from a flop: it is 1 exactly when the next state is not TWO. It has no combinational path from out_ready.
- MODE 0 states: EMPTY/ONE only.
  - in_ready = !out_valid | out_ready, combinational.
  - in_fire -> ONE, main<=in_data.
  - out_fire & !in_fire -> EMPTY.
- Ordering: words leave in acceptance order. No word is duplicated or dropped except by flush or rst.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in TWO.
- stall_cnt: increments by 1 on every cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1 and is cleared only by rst; flush does not clear it.
- flush:
  - Next state is EMPTY; main and skid are cleared to 0.
  - Any in_fire in the flush cycle is discarded. Any out_fire in the flush cycle completes normally.
  - MODE 1 in_ready returns to 1 on the next cycle.
- Priority: rst > flush > normal operation.
- Data is not interpreted: there is no arithmetic and no width change; DATA_W bits pass through unmodified.

## Timing
- Reset values (cycle after rst sampled high):
  - out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1 in both modes.
  - in_ready is forced 0 while rst is high.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N, i.e. 1 cycle when the stage is empty.
- Throughput: one word per cycle in both modes while out_ready=1 continuously.
- MODE 1 backpressure: after out_ready drops, one further word is accepted into skid, then in_ready=0 from the next cycle.
- MODE 1 release: after out_ready rises in TWO, in_ready=1 one cycle later.
- Simultaneous events:
  - In ONE, in_fire and out_fire in the same cycle keep occupancy at 1 and load the new word into main.
  - out_fire in TWO, with in_ready=0, never accepts a new word in the same cycle.
- rst mid-operation: held words are lost and no out_valid pulse follows. stall_cnt is cleared.
- in_data is sampled only on in_fire. out_data is stable while out_valid=1 and out_ready=0.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 and in_data=0xA5. Required: in_ready=0 during rst; afterwards out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming, both modes: send 0x01..0x10 on consecutive cycles with out_ready=1. Required: out_data 0x01..0x10 on consecutive cycles, each 1 cycle after acceptance, occupancy constant at 1.
- MODE 1 skid: stream 0x1,0x2,0x3 and drop out_ready after 0x1 is presented. Required: 0x2 lands in skid, in_ready=0, 0x3 is held upstream. stall_cnt counts each stalled cycle. On release the outputs are 0x1, 0x2, 0x3 in order with no loss.
- MODE 0 combinational ready: hold out_ready=0 with occupancy 1. Required: in_ready=0. Raise out_ready with in_valid=1 and in_data=0x7. Required: in_ready=1 in the same cycle, and 0x7 appears next cycle.
- Flush: occupancy 2 (words 0xB, 0xC). Pulse flush with in_valid=1 and in_data=0xD. Required: next cycle out_valid=0, occupancy=0, out_data=0, stall_cnt unchanged; 0xD is never output.
- Saturation: set CNT_W=4 and stall 20 cycles. Required: stall_cnt stops at 15 and stays at 15 until rst.
